// File: rtl/dsd_cnt_pkg.sv
// Shared types and next-state helpers for the T-flip-flop up/down counter family.
// Both the counter RTL and its bench model use next_count.
package dsd_cnt_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef struct packed {
        logic [31:0] value;
        logic        wrap;
    } cnt_step_t;

    // One counting step. An out-of-range q counts up to 0 like a terminal
    // count, so a corrupted counter recovers in one step.
    function automatic cnt_step_t next_count(
        input logic [31:0] q,
        input logic        x,
        input logic [31:0] modulus,
        input logic        sat
    );
        cnt_step_t step;
        step.value = q;
        step.wrap  = 1'b0;
        if (x == DIR_UP) begin
            if (q == modulus - 32'd1) begin
                step.value = sat ? q : 32'd0;
                step.wrap  = 1'b1;
            end else if (q > modulus - 32'd1) begin
                step.value = 32'd0;
                step.wrap  = 1'b1;
            end else begin
                step.value = q + 32'd1;
                step.wrap  = 1'b0;
            end
        end else begin
            if (q == 32'd0) begin
                step.value = sat ? q : modulus - 32'd1;
                step.wrap  = 1'b1;
            end else begin
                step.value = q - 32'd1;
                step.wrap  = 1'b0;
            end
        end
        return step;
    endfunction

    function automatic logic [31:0] clamp_load(
        input logic [31:0] din,
        input logic [31:0] modulus
    );
        logic [31:0] value;
        if (din >= modulus) begin
            value = modulus - 32'd1;
        end else begin
            value = din;
        end
        return value;
    endfunction

endpackage

// File: rtl/tff_updown_counter_tff_cell.sv
// Single T flip-flop storage cell: toggles on a rising clk edge when t is high.
module tff_cell (
    input  logic t,
    input  logic clk,
    input  logic reset,
    output logic q
);

    // Toggle storage with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/tff_updown_counter.sv
// Modulo-N (or saturating, with TFF_CNT_SATURATE_EN defined) up/down counter
// whose state lives entirely in tff_cell instances.
module tff_updown_counter
    import dsd_cnt_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             x,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

`ifdef TFF_CNT_SATURATE_EN
    localparam logic SAT_MODE = 1'b1;
`else
    localparam logic SAT_MODE = 1'b0;
`endif

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 32'd1);

    cnt_step_t        step_s;
    logic [31:0]      load_val_s;
    logic [WIDTH-1:0] next_s;
    logic [WIDTH-1:0] t_s;
    logic             wrap_next_s;
    logic             wrap_r;
    logic             unused_s;

    // Next count and wrap request: load beats enable, otherwise hold.
    always_comb begin
        step_s      = next_count(32'(q), x, 32'(MODULUS), SAT_MODE);
        load_val_s  = clamp_load(32'(din), 32'(MODULUS));
        next_s      = q;
        wrap_next_s = 1'b0;
        if (load) begin
            next_s      = load_val_s[WIDTH-1:0];
            wrap_next_s = 1'b0;
        end else if (en) begin
            next_s      = step_s.value[WIDTH-1:0];
            wrap_next_s = step_s.wrap;
        end else begin
            next_s      = q;
            wrap_next_s = 1'b0;
        end
    end

    assign unused_s = ^{step_s.value[31:WIDTH], load_val_s[31:WIDTH]};

    // A bit toggles exactly when it differs from its next value.
    assign t_s = q ^ next_s;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        tff_cell u_cell (
            .t     (t_s[i]),
            .clk   (clk),
            .reset (reset),
            .q     (q[i])
        );
    end

    // One-cycle wrap pulse following a wrapping (or blocked) step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrap_r <= 1'b0;
        end else begin
            wrap_r <= wrap_next_s;
        end
    end

    assign wrap = wrap_r;
    assign tc   = en & ~load & ((x & (q == MAX_Q)) | (~x & (q == {WIDTH{1'b0}})));

endmodule

// File: tb/tb_tff_updown_counter.sv
// Directed bench for tff_updown_counter: WIDTH=4/MODULUS=10 main instance plus a
// WIDTH=3/MODULUS=8 instance; expectations follow TFF_CNT_SATURATE_EN when defined.
module tb_tff_updown_counter;

`ifdef TFF_CNT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       en, x, load;
    logic [3:0] din;
    logic [3:0] q;
    logic       tc, wrap;

    logic       en8, x8, load8;
    logic [2:0] din8;
    logic [2:0] q8;
    logic       tc8, wrap8;

    int total_cnt;
    int bad_cnt;

    tff_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk(clk), .reset(reset), .en(en), .x(x), .load(load),
        .din(din), .q(q), .tc(tc), .wrap(wrap)
    );

    tff_updown_counter #(.WIDTH(3), .MODULUS(8)) dut8 (
        .clk(clk), .reset(reset), .en(en8), .x(x8), .load(load8),
        .din(din8), .q(q8), .tc(tc8), .wrap(wrap8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_qw(input string tag, input int eq, input int ew);
        chk({tag, ".q"}, 32'(q), 32'(eq));
        chk({tag, ".wrap"}, 32'(wrap), 32'(ew));
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        reset = 1'b1; en = 1'b0; x = 1'b1; load = 1'b0; din = 4'd0;
        en8 = 1'b0; x8 = 1'b1; load8 = 1'b0; din8 = 3'd0;
        #12;
        chk_qw("reset", 0, 0);
        chk("reset.tc", 32'(tc), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Case 1: asynchronous reset mid-cycle at q=7.
        load = 1'b1; din = 4'd7;
        tick();
        chk_qw("c1.load7", 7, 0);
        load = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_qw("c1.async", 0, 0);
        #1;
        reset = 1'b0;
        en = 1'b1; x = 1'b1;
        tick();
        chk_qw("c1.restart", 1, 0);

        // Case 2: count up 12 steps from 0.
        load = 1'b1; en = 1'b0; din = 4'd0;
        tick();
        chk_qw("c2.load0", 0, 0);
        load = 1'b0; en = 1'b1; x = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            chk($sformatf("c2.tc%0d", i), 32'(tc), ((i == 10) || (SAT && i > 10)) ? 32'd1 : 32'd0);
            tick();
            chk_qw($sformatf("c2.s%0d", i),
                   SAT ? ((i > 9) ? 9 : i) : (i % 10),
                   SAT ? ((i >= 10) ? 1 : 0) : ((i == 10) ? 1 : 0));
        end

        // Case 3: count down through 0.
        load = 1'b1; din = 4'd1; en = 1'b0;
        tick();
        chk_qw("c3.load1", 1, 0);
        load = 1'b0; en = 1'b1; x = 1'b0;
        chk("c3.tc_at1", 32'(tc), 32'd0);
        tick();
        chk_qw("c3.s1", 0, 0);
        chk("c3.tc_at0", 32'(tc), 32'd1);
        tick();
        chk_qw("c3.s2", SAT ? 0 : 9, 1);
        tick();
        chk_qw("c3.s3", SAT ? 0 : 8, SAT ? 1 : 0);

        // Case 4: load clamps and wins over enable.
        load = 1'b1; din = 4'd13; en = 1'b1; x = 1'b1;
        tick();
        chk_qw("c4.clamp", 9, 0);
        din = 4'd4;
        chk("c4.tc_load", 32'(tc), 32'd0);
        tick();
        chk_qw("c4.load4", 4, 0);

        // Case 5: direction toggling, then hold.
        din = 4'd5; en = 1'b0;
        tick();
        chk_qw("c5.load5", 5, 0);
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            x = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            chk_qw($sformatf("c5.dir%0d", i), (i % 2 == 0) ? 6 : 5, 0);
        end
        en = 1'b0; x = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("c5.tc%0d", i), 32'(tc), 32'd0);
            tick();
            chk_qw($sformatf("c5.hold%0d", i), 5, 0);
        end

        // Case 6: terminal behaviour from 8 up and from 0 down.
        load = 1'b1; din = 4'd8;
        tick();
        load = 1'b0; en = 1'b1; x = 1'b1;
        tick();
        chk_qw("c6.up1", 9, 0);
        tick();
        chk_qw("c6.up2", SAT ? 9 : 0, 1);
        tick();
        chk_qw("c6.up3", SAT ? 9 : 1, SAT ? 1 : 0);
        load = 1'b1; din = 4'd0; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; x = 1'b0;
        tick();
        chk_qw("c6.dn1", SAT ? 0 : 9, 1);
        tick();
        chk_qw("c6.dn2", SAT ? 0 : 8, SAT ? 1 : 0);
        en = 1'b0;

        // Case 2 again on the WIDTH=3, MODULUS=8 instance.
        chk("w3.start", 32'(q8), 32'd0);
        en8 = 1'b1; x8 = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            chk($sformatf("w3.tc%0d", i), 32'(tc8), ((i == 8) || (SAT && i > 8)) ? 32'd1 : 32'd0);
            tick();
            chk($sformatf("w3.q%0d", i), 32'(q8), SAT ? ((i > 7) ? 32'd7 : 32'(i)) : 32'(i % 8));
            chk($sformatf("w3.wrap%0d", i), 32'(wrap8),
                SAT ? ((i >= 8) ? 32'd1 : 32'd0) : ((i == 8) ? 32'd1 : 32'd0));
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
